// File: rtl/cpu7_icu_if.sv
// IFU/BIU-facing signal bundle for the cpu7 instruction cache unit.
// The ICU takes the slave modport; the fetch unit / bus side takes master.
interface cpu7_icu_if;
  logic        ifu_icu_req_ic1;
  logic [31:0] ifu_icu_addr_ic1;
  logic        icu_ifu_ack_ic1;
  logic        ifu_icu_cancel;
  logic [63:0] icu_ifu_data_ic2;
  logic        icu_ifu_data_valid_ic2;
  logic        icu_biu_req;
  logic [31:0] icu_biu_addr;
  logic        biu_icu_ack;
  logic [63:0] biu_icu_data;
  logic        biu_icu_data_valid;

  modport slave (
    input  ifu_icu_req_ic1, ifu_icu_addr_ic1, ifu_icu_cancel,
    input  biu_icu_ack, biu_icu_data, biu_icu_data_valid,
    output icu_ifu_ack_ic1, icu_ifu_data_ic2, icu_ifu_data_valid_ic2,
    output icu_biu_req, icu_biu_addr
  );

  modport master (
    output ifu_icu_req_ic1, ifu_icu_addr_ic1, ifu_icu_cancel,
    output biu_icu_ack, biu_icu_data, biu_icu_data_valid,
    input  icu_ifu_ack_ic1, icu_ifu_data_ic2, icu_ifu_data_valid_ic2,
    input  icu_biu_req, icu_biu_addr
  );
endinterface

// File: rtl/cpu7_icu.sv
// Uncached fetch path: one IFU request at a time turned into a single BIU read,
// with cancel/refetch support that lets an in-flight bus read drain unseen.
module cpu7_icu (
  input  logic        clk,
  input  logic        reset,
  cpu7_icu_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, BREQ, BWAIT} state_t;

  state_t      state;
  logic        stale;
  logic        pend_vld;
  logic [31:0] pend_addr;
  logic [31:0] addr_al;
  logic        ack;
  logic        bus_done;

  logic        biu_req_q;
  logic [31:0] biu_addr_q;
  logic        dv_q;
  logic [63:0] data_q;

  assign addr_al  = bus.ifu_icu_addr_ic1 & 32'hFFFF_FFF8;
  assign bus_done = (state == BWAIT) && bus.biu_icu_data_valid;

  // A cancel always frees the single IFU slot, so it may accept alongside.
  assign ack = bus.ifu_icu_req_ic1 && !reset &&
               (((state == IDLE) && !pend_vld && !dv_q) || bus.ifu_icu_cancel);

  assign bus.icu_ifu_ack_ic1        = ack;
  assign bus.icu_biu_req            = biu_req_q;
  assign bus.icu_biu_addr           = biu_addr_q;
  assign bus.icu_ifu_data_valid_ic2 = dv_q;
  assign bus.icu_ifu_data_ic2       = data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      stale      <= 1'b0;
      pend_vld   <= 1'b0;
      pend_addr  <= '0;
      biu_req_q  <= 1'b0;
      biu_addr_q <= '0;
      dv_q       <= 1'b0;
      data_q     <= '0;
    end else begin
      dv_q <= 1'b0;
      case (state)
        IDLE: begin
          if (ack) begin
            state      <= BREQ;
            biu_req_q  <= 1'b1;
            biu_addr_q <= addr_al;
          end
        end
        BREQ: begin
          // The bus request is never withdrawn; a cancel only marks it stale.
          if (bus.biu_icu_ack) begin
            state     <= BWAIT;
            biu_req_q <= 1'b0;
          end
          if (bus.ifu_icu_cancel) begin
            stale    <= 1'b1;
            pend_vld <= bus.ifu_icu_req_ic1;
            if (bus.ifu_icu_req_ic1) pend_addr <= addr_al;
          end
        end
        BWAIT: begin
          if (bus_done) begin
            stale    <= 1'b0;
            pend_vld <= 1'b0;
            if (bus.ifu_icu_cancel) begin
              // Transaction ends this cycle, so a new request goes straight out.
              if (bus.ifu_icu_req_ic1) begin
                state      <= BREQ;
                biu_req_q  <= 1'b1;
                biu_addr_q <= addr_al;
              end else begin
                state <= IDLE;
              end
            end else if (stale) begin
              if (pend_vld) begin
                state      <= BREQ;
                biu_req_q  <= 1'b1;
                biu_addr_q <= pend_addr;
              end else begin
                state <= IDLE;
              end
            end else begin
              dv_q   <= 1'b1;
              data_q <= bus.biu_icu_data;
              state  <= IDLE;
            end
          end else if (bus.ifu_icu_cancel) begin
            stale    <= 1'b1;
            pend_vld <= bus.ifu_icu_req_ic1;
            if (bus.ifu_icu_req_ic1) pend_addr <= addr_al;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read data outside BWAIT means the BIU broke its one-response-per-ack rule.
  always_ff @(posedge clk) begin
    if (!reset) assert (!(bus.biu_icu_data_valid && state != BWAIT));
  end
endmodule

// File: doc/cpu7_icu.md
CPU7_ICU -- requirements
Module: cpu7_icu

Interface
REQ-001 Parameters: none; the block SHALL have fixed widths (32-bit address, 64-bit fetch data).
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 ifu_icu_req_ic1  in  1  fetch request from IFU.
REQ-005 ifu_icu_addr_ic1  in  32  fetch byte address; bits [2:0] ignored.
REQ-006 icu_ifu_ack_ic1  out  1  request accepted this cycle (combinational).
REQ-007 ifu_icu_cancel  in  1  discard the in-flight fetch; may coincide with a new req.
REQ-008 icu_ifu_data_ic2  out  64  fetched doubleword, registered.
REQ-009 icu_ifu_data_valid_ic2  out  1  one-cycle pulse qualifying icu_ifu_data_ic2.
REQ-010 icu_biu_req  out  1  bus read request, registered, held until acked.
REQ-011 icu_biu_addr  out  32  bus address, {addr[31:3],3'b000}, stable while icu_biu_req=1.
REQ-012 biu_icu_ack  in  1  bus accepted request this cycle.
REQ-013 biu_icu_data  in  64  bus read data.
REQ-014 biu_icu_data_valid  in  1  bus read data valid; earliest one cycle after biu_icu_ack; one response per ack, in order.

Function
REQ-015 States SHALL be IDLE, BREQ (icu_biu_req=1, awaiting biu_icu_ack), BWAIT (awaiting biu_icu_data_valid); flags stale (current bus transaction cancelled) and pend_vld/pend_addr (accepted request not yet issued).
REQ-016 icu_ifu_ack_ic1 SHALL be ifu_icu_req_ic1 & (state==IDLE & ~pend_vld & ~data-out cycle | ifu_icu_cancel); at most one live IFU request SHALL exist.
REQ-017 Accept in IDLE: next cycle state=BREQ, icu_biu_req=1, icu_biu_addr from the accepted address.
REQ-018 BREQ & biu_icu_ack: next state=BWAIT, icu_biu_req=0; icu_biu_req SHALL never be withdrawn before ack.
REQ-019 BWAIT & biu_icu_data_valid & ~stale: next cycle icu_ifu_data_valid_ic2=1 with that data; state=IDLE.
REQ-020 Minimum latency: ack at T, biu ack at T+1, biu data at T+2 -> icu_ifu_data_valid_ic2 at T+3.
REQ-021 Cancel in BREQ or BWAIT: stale=1, current bus transaction completes normally on the bus, its data SHALL NOT be forwarded.
REQ-022 Cancel with req in BREQ/BWAIT: request acked same cycle, stored as pend (overwriting any prior pend).
REQ-023 Cancel without req: pend_vld cleared; stale set if a bus transaction is outstanding.
REQ-024 Stale response arrival: stale cleared, no IFU valid; if pend_vld, next cycle state=BREQ with pend_addr, pend_vld=0; else IDLE.
REQ-025 Cancel in IDLE with pend_vld=0 and no output pending: no state effect; accompanying req accepted per REQ-017.
REQ-026 Cancel in the same cycle as biu_icu_data_valid (non-stale): output next cycle SHALL be suppressed; any req handled as in IDLE.
REQ-027 Cancel in the same cycle icu_ifu_data_valid_ic2=1: data still presented; cancel has no bus effect; req handled as in IDLE.
REQ-028 icu_ifu_data_ic2 SHALL hold its last value when icu_ifu_data_valid_ic2=0.
REQ-029 biu_icu_data_valid outside BWAIT SHALL be ignored (assertion-flagged in simulation).

Reset
REQ-030 reset=1 SHALL force, on the next edge: state=IDLE, stale=0, pend_vld=0, icu_biu_req=0, icu_biu_addr=0, icu_ifu_data_valid_ic2=0, icu_ifu_data_ic2=0.
REQ-031 icu_ifu_ack_ic1 SHALL be 0 while reset=1.
REQ-032 Reset mid-transaction SHALL abandon all state; BIU is reset by the same reset.

Verification
REQ-033 Basic: req addr 0x1c000004 at T, biu ack T+1, data 0x0280_0c00_0280_0400 at T+2 -> ack T, icu_biu_addr 0x1c000000, data_valid=1 at T+3 with that data.
REQ-034 Backpressure: biu_icu_ack delayed 5 cycles -> icu_biu_req and addr stable 6 cycles, no second ack meanwhile.
REQ-035 Cancel+refetch in BWAIT: cancel+req 0x1c000100 -> acked same cycle, stale data dropped, next bus req addr 0x1c000100, only its data delivered.
REQ-036 Double cancel: second cancel+req 0x1c000200 before stale returns -> 0x1c000100 never issued; 0x1c000200 issued after stale data.
REQ-037 Cancel coincident with biu_icu_data_valid -> no IFU valid next cycle; subsequent req served normally.
REQ-038 Reset asserted in BREQ -> all outputs 0 next cycle; new req after reset acked in IDLE.
